// File: rtl/divider_pkg.sv
// Shared types and helpers for the radix divider: FSM state encoding and the
// sign-magnitude conversion used on operands and results.
package divider_pkg;

  // Widest operand the magnitude helper handles; the divider rejects wider WIDTH.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    FIXUP,
    DONE
  } state_t;

  // Two's-complement negate when neg is set; doubles as abs() for negative inputs.
  function automatic logic [MAX_W-1:0] cond_negate(input logic [MAX_W-1:0] v,
                                                   input logic             neg);
    return neg ? (~v + MAX_W'(1)) : v;
  endfunction

endpackage

// File: rtl/radix_divider_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and emit the quotient bit.
module radix_divider_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  assign shifted = {rem_in, dividend_msb};
  assign diff    = shifted - {2'b00, divisor};

  // A borrow out of the top bit means the divisor did not fit; restore.
  assign q_bit   = ~diff[WIDTH+1];
  assign rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/radix_divider.sv
// Iterative signed/unsigned integer divider retiring BITS_PER_CYCLE quotient bits
// per clock, with divide-by-zero / overflow flags and valid/ready on both sides.
module radix_divider
  import divider_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             data_valid_in,
  output logic             data_ready_out,
  input  logic             signed_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  input  logic             abort_in,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             div_by_zero_out,
  output logic             overflow_out,
  output logic             data_valid_out,
  input  logic             result_ready_in,
  output logic             busy_out
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic signed [WIDTH-1:0] MIN_S = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH < 2 || WIDTH > MAX_W) begin : g_bad_width
    $error("radix_divider: WIDTH must lie in 2..%0d", MAX_W);
  end
  if (BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
    $error("radix_divider: WIDTH must be a multiple of BITS_PER_CYCLE");
  end

  // Sign applied to a magnitude, truncated back to the operand width.
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                  input logic             neg);
    return WIDTH'(cond_negate(MAX_W'(mag), neg));
  endfunction

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt;
  logic                    accept, handshake, load_out;

  logic signed [WIDTH-1:0] dvd_s, dvs_s;
  logic [WIDTH:0]          rem_q;
  logic [WIDTH-1:0]        dvd_q, dvs_q, raw_dvd_q, dvd_next;
  logic                    dvd_neg_q, dvs_neg_q, zero_q, ovf_q;

  logic [BITS_PER_CYCLE:0][WIDTH:0] rem_chain;
  logic [BITS_PER_CYCLE-1:0]        q_chain;

  logic [WIDTH-1:0]        q_fix, r_fix;
  logic                    dbz_fix, ovf_fix;

  assign data_ready_out = (state == IDLE);
  assign busy_out       = (state != IDLE);
  assign accept         = data_valid_in && data_ready_out;
  assign handshake      = data_valid_out && result_ready_in;
  assign dvd_s          = dividend_in;
  assign dvs_s          = divisor_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    case (state)
      IDLE:    if (accept) state_nxt = DIVIDE;
      DIVIDE:  if (abort_in) state_nxt = IDLE;
               else if (cnt == '0) state_nxt = FIXUP;
      FIXUP:   if (abort_in) state_nxt = IDLE;
               else begin
                 load_out  = 1'b1;
                 state_nxt = DONE;
               end
      DONE:    if (abort_in || handshake) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                        cnt <= '0;
    else if (accept)                      cnt <= CW'(N - 1);
    else if (state == DIVIDE && cnt != '0) cnt <= cnt - CW'(1);
  end

  // ---- operand capture / iteration: datapath registers carry no reset ----
  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    radix_divider_step #(.WIDTH(WIDTH)) u_step (
      .rem_in       (rem_chain[i]),
      .dividend_msb (dvd_q[WIDTH-1-i]),
      .divisor      (dvs_q),
      .rem_out      (rem_chain[i+1]),
      .q_bit        (q_chain[BITS_PER_CYCLE-1-i])
    );
  end

  assign rem_chain[0] = rem_q;

  // Consumed dividend bits leave at the top while quotient bits enter at the bottom.
  if (BITS_PER_CYCLE == WIDTH) begin : g_full
    assign dvd_next = q_chain;
  end else begin : g_shift
    assign dvd_next = {dvd_q[WIDTH-BITS_PER_CYCLE-1:0], q_chain};
  end

  always_ff @(posedge clk_in) begin
    if (accept) begin
      dvd_neg_q <= signed_in & dividend_in[WIDTH-1];
      dvs_neg_q <= signed_in & divisor_in[WIDTH-1];
      dvd_q     <= apply_sign(dividend_in, signed_in & dividend_in[WIDTH-1]);
      dvs_q     <= apply_sign(divisor_in, signed_in & divisor_in[WIDTH-1]);
      raw_dvd_q <= dividend_in;
      zero_q    <= (divisor_in == '0);
      ovf_q     <= signed_in && (dvd_s == MIN_S) && (dvs_s == '1);
      rem_q     <= '0;
    end else if (state == DIVIDE) begin
      rem_q     <= rem_chain[BITS_PER_CYCLE];
      dvd_q     <= dvd_next;
    end
  end

  // ---- fixup: special cases first, then restore signs on the magnitudes ----
  always_comb begin
    q_fix   = dvd_q;
    r_fix   = rem_q[WIDTH-1:0];
    dbz_fix = 1'b0;
    ovf_fix = 1'b0;
    if (zero_q) begin
      q_fix   = '1;
      r_fix   = raw_dvd_q;
      dbz_fix = 1'b1;
    end else if (ovf_q) begin
      q_fix   = MIN_S;
      r_fix   = '0;
      ovf_fix = 1'b1;
    end else begin
      q_fix   = apply_sign(dvd_q, dvd_neg_q ^ dvs_neg_q);
      r_fix   = apply_sign(rem_q[WIDTH-1:0], dvd_neg_q);
    end
  end

  // ---- result registers: valid asserts the cycle after results land ----
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      quotient_out    <= '0;
      remainder_out   <= '0;
      div_by_zero_out <= 1'b0;
      overflow_out    <= 1'b0;
      data_valid_out  <= 1'b0;
    end else begin
      data_valid_out <= (state == DONE) && !abort_in && !handshake;
      if (accept) begin
        div_by_zero_out <= 1'b0;
        overflow_out    <= 1'b0;
      end else if (load_out) begin
        quotient_out    <= q_fix;
        remainder_out   <= r_fix;
        div_by_zero_out <= dbz_fix;
        overflow_out    <= ovf_fix;
      end
    end
  end

endmodule

// File: tb/tb_radix_divider.sv
// Scoreboard bench for radix_divider: expected results are queued on accept and
// popped by a monitor on each output handshake.
module tb_radix_divider;

  localparam int W   = 8;
  localparam int BPC = 2;
  localparam int N   = W / BPC;
  localparam int LAT = N + 2;

  logic         clk_in = 1'b0;
  logic         rst_n_in = 1'b0;
  logic         data_valid_in = 1'b0;
  logic         signed_in = 1'b0;
  logic         abort_in = 1'b0;
  logic         result_ready_in = 1'b0;
  logic [W-1:0] dividend_in = '0;
  logic [W-1:0] divisor_in = '0;
  logic         data_ready_out, div_by_zero_out, overflow_out, data_valid_out, busy_out;
  logic [W-1:0] quotient_out, remainder_out;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
  } res_t;

  res_t exp_q[$];
  res_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   rr_mode = 0;
  logic prev_valid = 1'b0;

  radix_divider #(.WIDTH(W), .BITS_PER_CYCLE(BPC)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .data_valid_in   (data_valid_in),
    .data_ready_out  (data_ready_out),
    .signed_in       (signed_in),
    .dividend_in     (dividend_in),
    .divisor_in      (divisor_in),
    .abort_in        (abort_in),
    .quotient_out    (quotient_out),
    .remainder_out   (remainder_out),
    .div_by_zero_out (div_by_zero_out),
    .overflow_out    (overflow_out),
    .data_valid_out  (data_valid_out),
    .result_ready_in (result_ready_in),
    .busy_out        (busy_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;

  // Reference: plain integer division, truncating toward zero in signed mode.
  function automatic res_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s);
    res_t e;
    int   sa, sb;
    e  = '0;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1;
    end else if (s && sa == -(2 ** (W - 1)) && sb == -1) begin
      e.q = W'(-(2 ** (W - 1))); e.r = '0; e.ovf = 1'b1;
    end else if (s) begin
      e.q = W'(sa / sb); e.r = W'(sa % sb);
    end else begin
      e.q = a / b; e.r = a % b;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_quotient"}, quotient_out, 0);
    chk({tag, "_remainder"}, remainder_out, 0);
    chk({tag, "_dbz"}, div_by_zero_out, 0);
    chk({tag, "_ovf"}, overflow_out, 0);
    chk({tag, "_valid"}, data_valid_out, 0);
    chk({tag, "_ready"}, data_ready_out, 1);
    chk({tag, "_busy"}, busy_out, 0);
  endtask

  // Called #1 after a clock edge; returns #1 after the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int guard;
    guard = 0;
    dividend_in = a; divisor_in = b; signed_in = s; data_valid_in = 1'b1;
    while (!data_ready_out && guard < 100) begin
      @(posedge clk_in); #1; guard++;
    end
    if (!data_ready_out) begin
      chk("accept_wait", data_ready_out, 1);
      data_valid_in = 1'b0;
    end else begin
      @(posedge clk_in); #1;
      data_valid_in = 1'b0;
      acc_cyc = cyc;
      exp_q.push_back(ref_div(a, b, s));
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || busy_out) && guard < 300) begin
      @(posedge clk_in); #1; guard++;
    end
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_busy", busy_out, 0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return {1'b1, {(W-1){1'b0}}};
      2:       return '1;
      3:       return W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  // Consumer: 0 always ready, 1 random stalls, 2 hold off.
  always @(posedge clk_in) begin
    #2;
    case (rr_mode)
      0:       result_ready_in = 1'b1;
      1:       result_ready_in = ($urandom_range(0, 3) != 0);
      default: result_ready_in = 1'b0;
    endcase
  end

  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      prev_valid = 1'b0;
    end else begin
      if (data_valid_out && !prev_valid) chk("latency", cyc - acc_cyc, LAT);
      if (data_valid_out && result_ready_in) begin
        chk("result_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("quotient", quotient_out, mon_e.q);
          chk("remainder", remainder_out, mon_e.r);
          chk("div_by_zero", div_by_zero_out, mon_e.dbz);
          chk("overflow", overflow_out, mon_e.ovf);
        end
      end
      prev_valid = data_valid_out;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish by %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    res_t hold_e;
    int   vcount;

    #12;
    chk_idle_outputs("reset");
    #10 rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    // Directed cases through the scoreboard.
    rr_mode = 0;
    issue(8'd200, 8'd7,  1'b0);
    issue(8'hF9,  8'h02, 1'b1);
    issue(8'h07,  8'hFE, 1'b1);
    issue(8'd13,  8'd0,  1'b0);
    issue(8'd13,  8'd0,  1'b1);
    issue(8'h80,  8'hFF, 1'b1);
    issue(8'h80,  8'h01, 1'b1);
    issue(8'hFF,  8'hFF, 1'b0);
    issue(8'h00,  8'h05, 1'b1);
    drain();

    // Consumer stall: outputs hold, busy pulse ignored, release returns to IDLE.
    rr_mode = 2;
    @(posedge clk_in); #1;
    hold_e = ref_div(8'd100, 8'd7, 1'b0);
    issue(8'd100, 8'd7, 1'b0);
    for (int g = 0; g < 50 && !data_valid_out; g++) @(negedge clk_in);
    chk("hold_valid_seen", data_valid_out, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      chk("hold_quotient", quotient_out, hold_e.q);
      chk("hold_remainder", remainder_out, hold_e.r);
      chk("hold_valid", data_valid_out, 1);
      chk("hold_ready", data_ready_out, 0);
      if (k == 1) begin
        data_valid_in = 1'b1; dividend_in = 8'd9; divisor_in = 8'd3;
      end else if (k == 2) begin
        data_valid_in = 1'b0;
      end
    end
    rr_mode = 0;
    @(posedge clk_in);
    @(posedge clk_in); #1;
    chk("release_ready", data_ready_out, 1);
    chk("release_valid", data_valid_out, 0);
    drain();

    // Abort during the second DIVIDE cycle.
    issue(8'd50, 8'd3, 1'b0);
    exp_q.delete();
    @(posedge clk_in); #1;
    abort_in = 1'b1;
    @(posedge clk_in); #1;
    abort_in = 1'b0;
    chk("abort_busy", busy_out, 0);
    chk("abort_ready", data_ready_out, 1);
    vcount = 0;
    repeat (LAT + 3) begin
      @(negedge clk_in);
      if (data_valid_out) vcount++;
    end
    chk("abort_no_valid", vcount, 0);
    @(posedge clk_in); #1;
    issue(8'd100, 8'd10, 1'b0);
    drain();

    // Asynchronous reset in the middle of DIVIDE.
    issue(8'd200, 8'd7, 1'b0);
    exp_q.delete();
    @(posedge clk_in); #3;
    rst_n_in = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    #2 rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    chk("post_rst_busy", busy_out, 0);

    // Randomized traffic with random consumer stalls.
    rr_mode = 1;
    for (int i = 0; i < 1200; i++) issue(pick(), pick(), 1'($urandom_range(0, 1)));
    rr_mode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
